// File: rtl/prozessor_pkg.sv
// -----------------------------------------------------------------------------
// prozessor_pkg
// Shared definitions for the processor front end: datapath widths and the
// state encoding of the instruction fetch unit (befehls_abruf).
// -----------------------------------------------------------------------------
package prozessor_pkg;

    localparam int ADR_BREITE   = 26;   // address width, equals Programmzahler width
    localparam int DATEN_BREITE = 32;   // instruction word width

    // Fetch unit states; the encoding is fixed so other blocks and debug
    // tooling can decode the state register directly.
    typedef enum logic [1:0] {
        ZUSTAND_ANFRAGE = 2'd0,   // issue the read request
        ZUSTAND_WARTEN  = 2'd1,   // request accepted, waiting for read data
        ZUSTAND_VOLL    = 2'd2,   // instruction held for the decoder
        ZUSTAND_WEITER  = 2'd3    // one-cycle PC advance pulse
    } zustand_t;

endpackage

// File: rtl/befehls_abruf.sv
// -----------------------------------------------------------------------------
// befehls_abruf - instruction fetch unit
//
// Reads the program counter, fetches the instruction word at that address
// from instruction memory (req/ack plus a one-cycle data-valid pulse), hands
// it to the decoder through a valid/accept handshake, and then pulses
// TaktSignal for one cycle so the Programmzahler advances. One fetch is
// outstanding at a time. All outputs are registered.
//
// Ports
//   Clock                 in   system clock, all state on posedge
//   Reset                 in   synchronous, active-high
//   AktuellerPC           in   current program counter
//   TaktSignal            out  one-cycle pulse: Programmzahler advances
//   SpeicherAdresse       out  fetch address, stable while SpeicherLesen=1
//   SpeicherLesen         out  read request
//   SpeicherBereit        in   memory accepts request (Lesen & Bereit)
//   SpeicherDatenGueltig  in   read data valid, one-cycle pulse
//   SpeicherDaten         in   read data
//   Befehl                out  fetched instruction
//   BefehlGueltig         out  Befehl is valid
//   BefehlAngenommen      in   decoder takes Befehl (Gueltig & Angenommen)
//   Sprung                in   PC redirect on this acceptance (handled by execute)
//   Fehler                out  sticky: a fetch timed out; cleared only by Reset
// -----------------------------------------------------------------------------
module befehls_abruf #(
    parameter int ADR_BREITE   = prozessor_pkg::ADR_BREITE,
    parameter int DATEN_BREITE = prozessor_pkg::DATEN_BREITE,
    parameter int TIMEOUT      = 255
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [ADR_BREITE-1:0]   AktuellerPC,
    output logic                    TaktSignal,
    output logic [ADR_BREITE-1:0]   SpeicherAdresse,
    output logic                    SpeicherLesen,
    input  logic                    SpeicherBereit,
    input  logic                    SpeicherDatenGueltig,
    input  logic [DATEN_BREITE-1:0] SpeicherDaten,
    output logic [DATEN_BREITE-1:0] Befehl,
    output logic                    BefehlGueltig,
    input  logic                    BefehlAngenommen,
    input  logic                    Sprung,
    output logic                    Fehler
);

    import prozessor_pkg::*;

    localparam int             ZW        = $clog2(TIMEOUT + 1);
    localparam logic [ZW-1:0]  TIMEOUT_W = ZW'(TIMEOUT);

    zustand_t                r_zustand,  w_zustand_n;
    logic                    r_lesen,    w_lesen_n;
    logic [ADR_BREITE-1:0]   r_adresse,  w_adresse_n;
    logic [DATEN_BREITE-1:0] r_befehl,   w_befehl_n;
    logic                    r_gueltig,  w_gueltig_n;
    logic                    r_takt,     w_takt_n;
    logic                    r_fehler,   w_fehler_n;
    logic [ZW-1:0]           r_zaehler,  w_zaehler_n;
    logic [ZW-1:0]           w_zaehler_plus;

    // The PC load on a jump is done by execute through the Programmzahler's
    // write port during WEITER; the fetch unit itself needs no action.
    logic w_unused_sprung;
    assign w_unused_sprung = Sprung;

    // Saturating increment: the counter never wraps back to zero.
    assign w_zaehler_plus = (r_zaehler == TIMEOUT_W) ? r_zaehler : r_zaehler + ZW'(1);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        w_zustand_n = r_zustand;
        w_lesen_n   = r_lesen;
        w_adresse_n = r_adresse;
        w_befehl_n  = r_befehl;
        w_gueltig_n = r_gueltig;
        w_takt_n    = 1'b0;
        w_fehler_n  = r_fehler;
        w_zaehler_n = r_zaehler;

        unique case (r_zustand)
            ZUSTAND_ANFRAGE: begin
                // Entry cycle samples the PC one cycle after the advance
                // pulse, so the request carries the updated address.
                if (!r_lesen) begin
                    w_lesen_n   = 1'b1;
                    w_adresse_n = AktuellerPC;
                end else if (SpeicherBereit) begin
                    w_lesen_n   = 1'b0;
                    w_zaehler_n = '0;
                    w_zustand_n = ZUSTAND_WARTEN;
                end
            end
            ZUSTAND_WARTEN: begin
                // A data pulse in the timeout cycle still wins.
                if (SpeicherDatenGueltig) begin
                    w_befehl_n  = SpeicherDaten;
                    w_gueltig_n = 1'b1;
                    w_zustand_n = ZUSTAND_VOLL;
                end else begin
                    // The counter includes the current cycle, so the fetch is
                    // abandoned at the end of the TIMEOUT-th waiting cycle.
                    w_zaehler_n = w_zaehler_plus;
                    if (w_zaehler_plus == TIMEOUT_W) begin
                        w_fehler_n  = 1'b1;
                        w_zustand_n = ZUSTAND_ANFRAGE;
                    end
                end
            end
            ZUSTAND_VOLL: begin
                if (BefehlAngenommen) begin
                    w_gueltig_n = 1'b0;
                    w_takt_n    = 1'b1;
                    w_zustand_n = ZUSTAND_WEITER;
                end
            end
            ZUSTAND_WEITER: begin
                w_zustand_n = ZUSTAND_ANFRAGE;
            end
            default: begin
                w_zustand_n = ZUSTAND_ANFRAGE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (Reset) begin
            r_zustand <= ZUSTAND_ANFRAGE;
            r_lesen   <= 1'b0;
            r_adresse <= '0;
            r_befehl  <= '0;
            r_gueltig <= 1'b0;
            r_takt    <= 1'b0;
            r_fehler  <= 1'b0;
            r_zaehler <= '0;
        end else begin
            r_zustand <= w_zustand_n;
            r_lesen   <= w_lesen_n;
            r_adresse <= w_adresse_n;
            r_befehl  <= w_befehl_n;
            r_gueltig <= w_gueltig_n;
            r_takt    <= w_takt_n;
            r_fehler  <= w_fehler_n;
            r_zaehler <= w_zaehler_n;
        end
    end

    assign TaktSignal      = r_takt;
    assign SpeicherAdresse = r_adresse;
    assign SpeicherLesen   = r_lesen;
    assign Befehl          = r_befehl;
    assign BefehlGueltig   = r_gueltig;
    assign Fehler          = r_fehler;

endmodule

// File: tb/tb_befehls_abruf.sv
// -----------------------------------------------------------------------------
// tb_befehls_abruf
// Self-checking bench for befehls_abruf. The bench plays Programmzahler,
// instruction memory and decoder. Its reference is transaction level: each
// request must carry the address the Programmzahler holds (PC+1, or jump
// target+1 after a redirect), each delivered instruction must equal the word
// the memory returned, and each acceptance must produce exactly one
// TaktSignal pulse.
// -----------------------------------------------------------------------------
module tb_befehls_abruf;

    import prozessor_pkg::*;

    localparam int TO = 4;

    logic                    Clock = 1'b0;
    logic                    Reset;
    logic [ADR_BREITE-1:0]   AktuellerPC;
    logic                    TaktSignal;
    logic [ADR_BREITE-1:0]   SpeicherAdresse;
    logic                    SpeicherLesen;
    logic                    SpeicherBereit;
    logic                    SpeicherDatenGueltig;
    logic [DATEN_BREITE-1:0] SpeicherDaten;
    logic [DATEN_BREITE-1:0] Befehl;
    logic                    BefehlGueltig;
    logic                    BefehlAngenommen;
    logic                    Sprung;
    logic                    Fehler;

    befehls_abruf #(
        .ADR_BREITE   (ADR_BREITE),
        .DATEN_BREITE (DATEN_BREITE),
        .TIMEOUT      (TO)
    ) dut (
        .Clock                (Clock),
        .Reset                (Reset),
        .AktuellerPC          (AktuellerPC),
        .TaktSignal           (TaktSignal),
        .SpeicherAdresse      (SpeicherAdresse),
        .SpeicherLesen        (SpeicherLesen),
        .SpeicherBereit       (SpeicherBereit),
        .SpeicherDatenGueltig (SpeicherDatenGueltig),
        .SpeicherDaten        (SpeicherDaten),
        .Befehl               (Befehl),
        .BefehlGueltig        (BefehlGueltig),
        .BefehlAngenommen     (BefehlAngenommen),
        .Sprung               (Sprung),
        .Fehler               (Fehler)
    );

    always #5 Clock = ~Clock;

    int vektoren       = 0;
    int fehlvergleiche = 0;

    // Programmzahler model and pending redirect
    logic [ADR_BREITE-1:0] pc_modell;
    logic                  sprung_merker;
    logic [ADR_BREITE-1:0] sprung_ziel;
    logic                  fehler_erwartet;

    task automatic check(input string tag, input logic [31:0] ist, input logic [31:0] soll);
        vektoren++;
        assert (ist === soll)
        else begin
            fehlvergleiche++;
            $error("FAIL %s: observed %0h expected %0h", tag, ist, soll);
        end
    endtask

    // One clock cycle. The Programmzahler advances on the edge that ends a
    // cycle in which TaktSignal was high; a jump loads target and adds 1.
    task automatic takt();
        logic t_vorher;
        t_vorher = TaktSignal;
        @(posedge Clock);
        #1;
        if (t_vorher === 1'b1) begin
            pc_modell     = sprung_merker ? sprung_ziel + 1'b1 : pc_modell + 1'b1;
            sprung_merker = 1'b0;
            AktuellerPC   = pc_modell;
        end
    endtask

    task automatic warte_lesen(input string tag);
        int n;
        n = 0;
        while (SpeicherLesen !== 1'b1 && n < 8) begin
            takt();
            n++;
        end
        check({tag, ":lesen_an"}, 32'(SpeicherLesen), 32'd1);
    endtask

    // One complete instruction: d cycles of memory not ready, data in the
    // lat-th waiting cycle, stall cycles of decoder back-pressure, then accept.
    task automatic ablauf(input int d, input int lat, input int stall,
                          input logic sprung, input logic [ADR_BREITE-1:0] ziel,
                          input string tag);
        logic [ADR_BREITE-1:0]   adr;
        logic [DATEN_BREITE-1:0] daten;
        warte_lesen(tag);
        adr = pc_modell;
        check({tag, ":adresse"}, 32'(SpeicherAdresse), 32'(adr));
        for (int i = 0; i < d; i++) begin
            SpeicherDatenGueltig = 1'($urandom_range(0, 1));   // stray pulse, must be ignored
            SpeicherDaten        = $urandom;
            takt();
            check({tag, ":lesen_halten"}, 32'(SpeicherLesen), 32'd1);
            check({tag, ":adresse_halten"}, 32'(SpeicherAdresse), 32'(adr));
            check({tag, ":kein_takt_anfrage"}, 32'(TaktSignal), 32'd0);
        end
        SpeicherDatenGueltig = 1'b0;
        SpeicherBereit       = 1'b1;
        takt();
        SpeicherBereit = 1'b0;
        check({tag, ":lesen_aus"}, 32'(SpeicherLesen), 32'd0);
        for (int i = 1; i < lat; i++) begin
            takt();
            check({tag, ":noch_ungueltig"}, 32'(BefehlGueltig), 32'd0);
        end
        daten                = $urandom;
        SpeicherDaten        = daten;
        SpeicherDatenGueltig = 1'b1;
        takt();
        SpeicherDatenGueltig = 1'b0;
        SpeicherDaten        = $urandom;
        check({tag, ":gueltig"}, 32'(BefehlGueltig), 32'd1);
        check({tag, ":befehl"}, 32'(Befehl), 32'(daten));
        check({tag, ":fehler"}, 32'(Fehler), 32'(fehler_erwartet));
        for (int i = 0; i < stall; i++) begin
            BefehlAngenommen     = 1'b0;
            Sprung               = 1'($urandom_range(0, 1));
            SpeicherDatenGueltig = 1'($urandom_range(0, 1));
            SpeicherDaten        = $urandom;
            takt();
            check({tag, ":stall_gueltig"}, 32'(BefehlGueltig), 32'd1);
            check({tag, ":stall_befehl"}, 32'(Befehl), 32'(daten));
            check({tag, ":stall_takt"}, 32'(TaktSignal), 32'd0);
        end
        SpeicherDatenGueltig = 1'b0;
        BefehlAngenommen     = 1'b1;
        Sprung               = sprung;
        takt();
        BefehlAngenommen = 1'b0;
        Sprung           = 1'b0;
        if (sprung) begin
            sprung_merker = 1'b1;
            sprung_ziel   = ziel;
        end
        check({tag, ":takt_puls"}, 32'(TaktSignal), 32'd1);
        check({tag, ":gueltig_aus"}, 32'(BefehlGueltig), 32'd0);
        takt();
        check({tag, ":takt_ende"}, 32'(TaktSignal), 32'd0);
        check({tag, ":anfrage_eintritt"}, 32'(SpeicherLesen), 32'd0);
    endtask

    initial begin
        logic [DATEN_BREITE-1:0] d0;
        logic [ADR_BREITE-1:0]   ziel;

        Reset                = 1'b1;
        AktuellerPC          = '0;
        SpeicherBereit       = 1'b0;
        SpeicherDatenGueltig = 1'b0;
        SpeicherDaten        = '0;
        BefehlAngenommen     = 1'b0;
        Sprung               = 1'b0;
        pc_modell            = '0;
        sprung_merker        = 1'b0;
        sprung_ziel          = '0;
        fehler_erwartet      = 1'b0;

        // Reset for 3 cycles
        repeat (3) takt();
        check("reset:lesen",   32'(SpeicherLesen),   32'd0);
        check("reset:gueltig", 32'(BefehlGueltig),   32'd0);
        check("reset:befehl",  32'(Befehl),          32'd0);
        check("reset:fehler",  32'(Fehler),          32'd0);
        check("reset:takt",    32'(TaktSignal),      32'd0);
        check("reset:adresse", 32'(SpeicherAdresse), 32'd0);

        // Zero-wait fetch timeline: Lesen at 1, valid at 3, pulse at 4
        Reset            = 1'b0;
        SpeicherBereit   = 1'b1;
        BefehlAngenommen = 1'b1;
        takt();
        check("zeit:lesen_z1",   32'(SpeicherLesen),   32'd1);
        check("zeit:adresse_z1", 32'(SpeicherAdresse), 32'd0);
        takt();
        check("zeit:lesen_z2",   32'(SpeicherLesen),   32'd0);
        check("zeit:gueltig_z2", 32'(BefehlGueltig),   32'd0);
        d0                   = 32'hC0DE_0001;
        SpeicherDaten        = d0;
        SpeicherDatenGueltig = 1'b1;
        takt();
        SpeicherDatenGueltig = 1'b0;
        check("zeit:gueltig_z3", 32'(BefehlGueltig), 32'd1);
        check("zeit:befehl_z3",  32'(Befehl),        32'(d0));
        check("zeit:takt_z3",    32'(TaktSignal),    32'd0);
        takt();
        check("zeit:takt_z4",    32'(TaktSignal),    32'd1);
        check("zeit:gueltig_z4", 32'(BefehlGueltig), 32'd0);
        SpeicherBereit   = 1'b0;
        BefehlAngenommen = 1'b0;
        takt();
        check("zeit:takt_z5",  32'(TaktSignal),    32'd0);
        check("zeit:lesen_z5", 32'(SpeicherLesen), 32'd0);
        takt();
        check("zeit:lesen_z6",   32'(SpeicherLesen),   32'd1);
        check("zeit:adresse_z6", 32'(SpeicherAdresse), 32'd1);

        // Memory not ready for 5 cycles: request held, no pulse
        for (int i = 0; i < 5; i++) begin
            takt();
            check("bereit0:lesen",   32'(SpeicherLesen),   32'd1);
            check("bereit0:adresse", 32'(SpeicherAdresse), 32'd1);
            check("bereit0:takt",    32'(TaktSignal),      32'd0);
        end
        SpeicherBereit = 1'b1;
        takt();
        SpeicherBereit = 1'b0;
        check("timeout:warten", 32'(SpeicherLesen), 32'd0);

        // Memory never answers: Fehler after the 4th waiting cycle, re-issue
        for (int i = 0; i < TO - 1; i++) begin
            takt();
            check("timeout:fehler_noch_0", 32'(Fehler), 32'd0);
        end
        takt();
        check("timeout:fehler",  32'(Fehler),        32'd1);
        check("timeout:lesen_0", 32'(SpeicherLesen), 32'd0);
        takt();
        check("timeout:lesen_neu",   32'(SpeicherLesen),   32'd1);
        check("timeout:adresse_neu", 32'(SpeicherAdresse), 32'd1);
        check("timeout:fehler_bleibt", 32'(Fehler),       32'd1);
        fehler_erwartet = 1'b1;

        // Decoder stalls for 10 cycles, then accepts
        ablauf(0, 1, 10, 1'b0, '0, "stall");

        // Redirect to 0x100: the following fetch uses 0x101
        ablauf(1, 2, 0, 1'b1, 26'h100, "sprung");
        warte_lesen("nach_sprung");
        check("nach_sprung:adresse", 32'(SpeicherAdresse), 32'h101);

        // Reset during WARTEN, then a late data pulse that must be ignored
        SpeicherBereit = 1'b1;
        takt();
        SpeicherBereit = 1'b0;
        takt();
        Reset = 1'b1;
        takt();
        Reset = 1'b0;
        check("reset_warten:gueltig", 32'(BefehlGueltig), 32'd0);
        check("reset_warten:fehler",  32'(Fehler),        32'd0);
        check("reset_warten:lesen",   32'(SpeicherLesen), 32'd0);
        fehler_erwartet      = 1'b0;
        SpeicherDaten        = 32'hDEAD_BEEF;
        SpeicherDatenGueltig = 1'b1;
        takt();
        SpeicherDatenGueltig = 1'b0;
        check("reset_warten:lesen_neu", 32'(SpeicherLesen),   32'd1);
        check("reset_warten:ignoriert", 32'(BefehlGueltig),   32'd0);
        check("reset_warten:adresse",   32'(SpeicherAdresse), 32'(pc_modell));

        // Jump to the top of the address space: the next fetch wraps to 0
        ablauf(0, TO, 0, 1'b1, '1, "wrap");
        warte_lesen("nach_wrap");
        check("nach_wrap:adresse", 32'(SpeicherAdresse), 32'd0);

        // Randomized traffic, data latency up to the timeout boundary
        for (int n = 0; n < 40; n++) begin
            ziel = ADR_BREITE'($urandom);
            ablauf($urandom_range(0, 3), $urandom_range(1, TO), $urandom_range(0, 3),
                   1'($urandom_range(0, 3) == 0), ziel, "zufall");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vektoren, fehlvergleiche);
        $finish;
    end

endmodule
